// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch-time branch predictions, matched against execute outcomes
// to produce registered predictor training pulses and mispredict flushes.
module branch_resolve_queue #(
    parameter int p_depth    = 4,
    parameter int p_pc_nbits = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pred_val,
    output logic                      pred_rdy,
    input  logic [p_pc_nbits-1:0]     pred_pc,
    input  logic                      pred_taken,
    input  logic                      resolve_val,
    output logic                      resolve_rdy,
    input  logic                      resolve_taken,
    input  logic                      squash,
    output logic                      update_en,
    output logic                      update_val,
    output logic [p_pc_nbits-1:0]     update_pc,
    output logic                      mispredict,
    output logic [$clog2(p_depth):0]  count,
    output logic [15:0]               mispred_count
);

    localparam int unsigned AW = $clog2(p_depth);
    localparam int unsigned CW = AW + 1;

    logic [p_pc_nbits-1:0] mem_pc    [p_depth];
    logic                  mem_taken [p_depth];
    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;

    logic enq;
    logic deq;
    logic mis;
    logic flush;
    logic [p_pc_nbits-1:0] head_pc;
    logic                  head_taken;

    assign pred_rdy    = (count != CW'(p_depth));
    assign resolve_rdy = (count != '0);

    always_comb begin
        enq        = pred_val && pred_rdy;
        deq        = resolve_val && resolve_rdy;
        head_pc    = mem_pc[head];
        head_taken = mem_taken[head];
        mis        = deq && (head_taken != resolve_taken);
        flush      = mis || squash;
    end

    // A flush drops every entry and any same-cycle enqueue; the resolve itself still retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < p_depth; i++) begin
                mem_pc[i]    <= '0;
                mem_taken[i] <= 1'b0;
            end
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (enq) begin
                mem_pc[tail]    <= pred_pc;
                mem_taken[tail] <= pred_taken;
                tail            <= tail + AW'(1);
            end
            if (deq) begin
                head <= head + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            update_en     <= 1'b0;
            update_val    <= 1'b0;
            update_pc     <= '0;
            mispredict    <= 1'b0;
            mispred_count <= '0;
        end else begin
            update_en  <= deq;
            update_val <= deq && resolve_taken;
            update_pc  <= deq ? head_pc : '0;
            mispredict <= mis;
            if (mis && (mispred_count != '1)) begin
                mispred_count <= mispred_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed and randomized checks of branch_resolve_queue against a queue-based
// reference model of the in-flight predictions.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int PCW   = 32;

    typedef struct {
        logic [PCW-1:0] pc;
        logic           taken;
    } entry_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     pred_val;
    logic                     pred_rdy;
    logic [PCW-1:0]           pred_pc;
    logic                     pred_taken;
    logic                     resolve_val;
    logic                     resolve_rdy;
    logic                     resolve_taken;
    logic                     squash;
    logic                     update_en;
    logic                     update_val;
    logic [PCW-1:0]           update_pc;
    logic                     mispredict;
    logic [$clog2(DEPTH):0]   count;
    logic [15:0]              mispred_count;

    int tests = 0;
    int fails = 0;

    entry_t q[$];
    int     mcnt;
    logic   exp_en, exp_val, exp_mis;
    logic [PCW-1:0] exp_pc;

    branch_resolve_queue #(.p_depth(DEPTH), .p_pc_nbits(PCW)) dut (
        .clk(clk), .reset(reset),
        .pred_val(pred_val), .pred_rdy(pred_rdy), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .resolve_val(resolve_val), .resolve_rdy(resolve_rdy), .resolve_taken(resolve_taken),
        .squash(squash),
        .update_en(update_en), .update_val(update_val), .update_pc(update_pc),
        .mispredict(mispredict), .count(count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pred_val = 0; pred_pc = '0; pred_taken = 0;
        resolve_val = 0; resolve_taken = 0; squash = 0;
    endtask

    // One clock: check readiness, advance the model, then check registered outputs.
    task automatic step();
        entry_t e;
        logic   do_enq, do_deq;
        chk("pred_rdy", 32'(pred_rdy), 32'(q.size() != DEPTH));
        chk("resolve_rdy", 32'(resolve_rdy), 32'(q.size() != 0));
        do_enq = pred_val && (q.size() < DEPTH);
        do_deq = resolve_val && (q.size() > 0);
        exp_en = 0; exp_val = 0; exp_pc = '0; exp_mis = 0;
        if (do_deq) begin
            e = q.pop_front();
            exp_en  = 1;
            exp_val = resolve_taken;
            exp_pc  = e.pc;
            exp_mis = (e.taken != resolve_taken);
            if (exp_mis && mcnt < 16'hFFFF) mcnt++;
        end
        if (exp_mis || squash) q.delete();
        else if (do_enq) q.push_back('{pred_pc, pred_taken});
        @(posedge clk);
        #1;
        chk("update_en", 32'(update_en), 32'(exp_en));
        chk("update_val", 32'(update_val), 32'(exp_val));
        chk("update_pc", update_pc, exp_pc);
        chk("mispredict", 32'(mispredict), 32'(exp_mis));
        chk("count", 32'(count), 32'(q.size()));
        chk("mispred_count", 32'(mispred_count), 32'(mcnt));
    endtask

    task automatic enq(input logic [PCW-1:0] pc, input logic t);
        idle(); pred_val = 1; pred_pc = pc; pred_taken = t;
        step();
    endtask

    task automatic res(input logic t);
        idle(); resolve_val = 1; resolve_taken = t;
        step();
    endtask

    initial begin
        idle();
        reset = 1;
        mcnt = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("rst_update_en", 32'(update_en), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pred_rdy", 32'(pred_rdy), 32'd1);
        chk("rst_resolve_rdy", 32'(resolve_rdy), 32'd0);

        // Fill to capacity, then a rejected fifth enqueue
        enq(32'h100, 1); enq(32'h104, 0); enq(32'h108, 1); enq(32'h10C, 0);
        chk("full_pred_rdy", 32'(pred_rdy), 32'd0);
        enq(32'h110, 1);
        chk("full_count", 32'(count), 32'd4);

        // Drain with matching outcomes
        res(1); res(0); res(1); res(0);
        chk("drained_rdy", 32'(resolve_rdy), 32'd0);

        // Mispredict on the oldest of three flushes the rest
        enq(32'h200, 0); enq(32'h204, 0); enq(32'h208, 0);
        res(1);
        chk("mis_count", 32'(count), 32'd0);
        chk("mis_counter", 32'(mispred_count), 32'd1);

        // Concurrent enqueue + matching resolve across pointer wrap
        enq(32'h300, 1); enq(32'h304, 0);
        for (int i = 0; i < 10; i++) begin
            idle();
            pred_val = 1; pred_pc = 32'h308 + 32'(4 * i); pred_taken = 1'(i);
            resolve_val = 1; resolve_taken = q[0].taken;
            step();
            chk("wrap_count", 32'(count), 32'd2);
        end
        res(q[0].taken); res(q[0].taken);

        // Squash with valid resolve and enqueue at count 3
        enq(32'h400, 1); enq(32'h404, 1); enq(32'h408, 0);
        idle();
        squash = 1; resolve_val = 1; resolve_taken = 1;
        pred_val = 1; pred_pc = 32'h40C; pred_taken = 1;
        step();
        chk("squash_pc", update_pc, 32'h400);
        chk("squash_count", 32'(count), 32'd0);

        // Asynchronous reset in the cycle after a resolve
        enq(32'h500, 0); enq(32'h504, 1);
        res(1);
        idle();
        #2 reset = 1;
        #1;
        chk("arst_update_en", 32'(update_en), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_mispred_count", 32'(mispred_count), 32'd0);
        q.delete(); mcnt = 0;
        @(posedge clk);
        #1 reset = 0;
        #1;
        chk("arst_pred_rdy", 32'(pred_rdy), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            pred_val    = ($urandom_range(0, 99) < 60);
            pred_pc     = $urandom;
            pred_taken  = 1'($urandom);
            resolve_val = ($urandom_range(0, 99) < 50);
            if (q.size() > 0)
                resolve_taken = ($urandom_range(0, 9) < 2) ? ~q[0].taken : q[0].taken;
            else
                resolve_taken = 1'($urandom);
            squash = ($urandom_range(0, 99) < 4);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
